// File: rtl/bcd_xs3_converter_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) with start/busy/done handshake.
// Define EXCESS3_EN to emit excess-3 coded digits instead of plain 8421 BCD.
module bcd_xs3_converter_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0] scratch;
  logic [CNT_W-1:0] count;
  logic [BCD_W-1:0] scratch_adj;
  logic [BCD_W-1:0] scratch_next;
  logic [WIDTH-1:0] shift_next;

  // Digits of 5 or more get +3 so the following doubling carries into the next decade.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] encode(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
`ifdef EXCESS3_EN
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
`else
    r = v;
`endif
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    scratch_adj                = add3_digits(scratch);
    {scratch_next, shift_next} = {scratch_adj, shift_reg} << 1;
  end

  // Datapath and registered handshake outputs; done lands one cycle after the DONE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
      bcd_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            count     <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_next;
          count     <= count - CNT_W'(1);
        end
        DONE:    bcd_out <= encode(scratch);
        default: ;
      endcase
      busy <= (state_next == SHIFT);
      done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_bcd_xs3_converter_seq.sv
// Directed bench for bcd_xs3_converter_seq (WIDTH=8, DIGITS=3); honours EXCESS3_EN.
module tb_bcd_xs3_converter_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_out;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int done_cyc;
  int d1;
  int d2;
  logic [BCD_W-1:0] last_exp;

  bcd_xs3_converter_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [BCD_W-1:0] enc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
`ifdef EXCESS3_EN
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
`else
    r = v;
`endif
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    int n;
    n = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return enc(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One conversion with exact cycle-by-cycle busy/done/bcd_out expectations.
  task automatic convert(input string tag, input int v, input logic [BCD_W-1:0] exp,
                         input bit hold, input int inject_k);
    logic [1:0] flags;
    start  = 1'b1;
    bin_in = WIDTH'(v);
    tick();
    if (!hold) start = 1'b0;
    for (int k = 0; k <= WIDTH + 1; k++) begin
      if (inject_k >= 0 && k == inject_k) begin
        start  = 1'b1;
        bin_in = 8'd7;
      end else if (inject_k >= 0 && k == inject_k + 1) begin
        start = 1'b0;
      end
      flags = (k < WIDTH) ? 2'b10 : ((k == WIDTH) ? 2'b00 : 2'b01);
      check({tag, " busy/done"}, 32'({busy, done}), 32'(flags));
      if (k <= WIDTH) begin
        check({tag, " bcd_out held"}, 32'(bcd_out), 32'(last_exp));
        tick();
      end else begin
        check({tag, " result"}, 32'(bcd_out), 32'(exp));
        done_cyc = cyc;
      end
    end
    last_exp = exp;
    if (!hold) begin
      tick();
      check({tag, " idle after done"}, 32'({busy, done}), 32'(2'b00));
      check({tag, " result kept"}, 32'(bcd_out), 32'(exp));
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    bin_in   = '0;
    last_exp = '0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset bcd_out", 32'(bcd_out), 32'(0));
    #2 reset = 1'b0;
    tick();
    check("idle after reset", 32'({busy, done}), 32'(2'b00));

    // zero and maximum / two-digit values
    convert("zero", 0, enc(12'h000), 1'b0, -1);
    convert("max255", 255, enc(12'h255), 1'b0, -1);
    convert("v99", 99, enc(12'h099), 1'b0, -1);

    // start pulsed mid-conversion with a different operand is ignored
    convert("v128 inject", 128, enc(12'h128), 1'b0, 2);

    // start held high: back-to-back conversions
    convert("held42", 42, enc(12'h042), 1'b1, -1);
    d1 = done_cyc;
    convert("held200", 200, enc(12'h200), 1'b1, -1);
    d2 = done_cyc;
    start = 1'b0;
    check("held done spacing", 32'(d2 - d1), 32'(10));
    tick();
    check("held idle after", 32'({busy, done}), 32'(2'b00));

    // asynchronous reset during SHIFT aborts
    start  = 1'b1;
    bin_in = 8'd173;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #3 reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort done", 32'(done), 32'(0));
    check("abort bcd_out", 32'(bcd_out), 32'(0));
    #2 reset = 1'b0;
    last_exp = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("no done after abort", 32'({busy, done}), 32'(2'b00));
    end
    convert("v173 after abort", 173, enc(12'h173), 1'b0, -1);

    // full operand sweep against the decimal reference
    for (int v = 0; v < (1 << WIDTH); v++) begin
      convert($sformatf("sweep%0d", v), v, ref_bcd(v), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
